// File: rtl/uop_datapath.sv
// Micro-op datapath: register file, 2*WIDTH-bit PC and a stallable req/ack memory port.
// Single-cycle ops retire in IDLE; LOAD/STORE park in MEM until the memory acknowledges.
module uop_datapath #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter logic [2*WIDTH-1:0] PC_RESET = 16'hAABB,
    localparam int RW = $clog2(NUM_REGS),
    localparam int AW = 2 * WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uop_valid,
    output logic            uop_ready,
    input  logic [2:0]      uop_op,
    input  logic [RW-1:0]   uop_rd,
    input  logic [RW-1:0]   uop_rs,
    input  logic            uop_use_pc,
    input  logic            uop_pc_inc,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [AW-1:0]   pc,
    output logic            uop_done,
    output logic            err,
    output logic            dbgState
);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_MOV     = 3'd1;
    localparam logic [2:0] OP_LOAD    = 3'd2;
    localparam logic [2:0] OP_STORE   = 3'd3;
    localparam logic [2:0] OP_PC_INC  = 3'd4;
    localparam logic [2:0] OP_PC_DEC  = 3'd5;
    localparam logic [2:0] OP_PC_LOAD = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

    state_t state, stateNext;
    logic [WIDTH-1:0] regFile [NUM_REGS];
    logic             latchWe;
    logic [RW-1:0]    latchRd;
    logic             latchPcInc;
    logic             accept;
    logic             memFinish;
    logic             doneNext;

    assign dbgState = state;

    // Handshake: a micro-op transfers on a rising edge where uop_valid && uop_ready
    // and rst is low; uop_ready depends only on state, never on uop_valid.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        memFinish = 1'b0;
        doneNext  = 1'b0;
        uop_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                uop_ready = 1'b1;
                if (uop_valid) begin
                    accept = 1'b1;
                    if (uop_op == OP_LOAD || uop_op == OP_STORE) begin
                        stateNext = MEM;
                    end else begin
                        doneNext = 1'b1;
                    end
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = latchWe;
                if (mem_ack) begin
                    memFinish = 1'b1;
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= PC_RESET;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            latchWe    <= 1'b0;
            latchRd    <= '0;
            latchPcInc <= 1'b0;
            uop_done   <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
        end else begin
            state    <= stateNext;
            uop_done <= doneNext;
            if (accept) begin
                case (uop_op)
                    OP_NOP:     ;
                    OP_MOV:     regFile[uop_rd] <= regFile[uop_rs];
                    OP_PC_INC:  pc <= pc + AW'(1);
                    OP_PC_DEC:  pc <= pc - AW'(1);
                    OP_PC_LOAD: pc <= {regFile[uop_rd], regFile[uop_rs]};
                    OP_RSVD:    err <= 1'b1;
                    default: begin
                        // LOAD/STORE: address and data are frozen here for the whole MEM stay
                        mem_addr   <= uop_use_pc ? pc : {regFile[1], regFile[0]};
                        mem_wdata  <= regFile[uop_rs];
                        latchWe    <= (uop_op == OP_STORE);
                        latchRd    <= uop_rd;
                        latchPcInc <= uop_pc_inc;
                    end
                endcase
            end
            if (memFinish) begin
                if (!latchWe) regFile[latchRd] <= mem_rdata;
                if (latchPcInc) pc <= pc + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uop_datapath.sv
// Directed bench for uop_datapath: the bench plays the memory and reads registers back
// through PC_LOAD (pc = {reg[rd], reg[rs]}) and STORE write data.
module tb_uop_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        uop_valid;
    logic        uop_ready;
    logic [2:0]  uop_op;
    logic [1:0]  uop_rd;
    logic [1:0]  uop_rs;
    logic        uop_use_pc;
    logic        uop_pc_inc;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [15:0] pc;
    logic        uop_done;
    logic        err;
    logic        dbgState;

    int nCompared   = 0;
    int nMismatched = 0;

    uop_datapath dut (
        .clk(clk), .rst(rst),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_op(uop_op),
        .uop_rd(uop_rd), .uop_rs(uop_rs), .uop_use_pc(uop_use_pc), .uop_pc_inc(uop_pc_inc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .uop_done(uop_done), .err(err), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic usePc, input logic pcInc);
        uop_valid  = 1'b1;
        uop_op     = op;
        uop_rd     = rd;
        uop_rs     = rs;
        uop_use_pc = usePc;
        uop_pc_inc = pcInc;
        step();
        uop_valid  = 1'b0;
    endtask

    // LOAD with immediate ack: puts val into register r without touching the PC
    task automatic loadReg(input logic [1:0] r, input logic [7:0] val);
        issue(3'd2, r, 2'd0, 1'b0, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = val;
        step();
        mem_ack   = 1'b0;
    endtask

    task automatic setPc(input logic [15:0] v);
        loadReg(2'd3, v[15:8]);
        loadReg(2'd2, v[7:0]);
        issue(3'd6, 2'd3, 2'd2, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uop_valid = 1'b1; uop_op = 3'd4; uop_rd = '0; uop_rs = '0;
        uop_use_pc = 1'b0; uop_pc_inc = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        rst = 1'b0;
        uop_valid = 1'b0;
        nCompared++; if (pc !== 16'hAABB) begin nMismatched++; $display("FAIL reset_pc: got %h want %h", pc, 16'hAABB); end
        nCompared++; if (uop_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_ready: got %b want 1", uop_ready); end
        nCompared++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin nMismatched++; $display("FAIL reset_req_we: got %b%b want 00", mem_req, mem_we); end
        nCompared++; if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin nMismatched++; $display("FAIL reset_addr_wdata: got %h/%h want 0000/00", mem_addr, mem_wdata); end
        nCompared++; if (uop_done !== 1'b0 || err !== 1'b0) begin nMismatched++; $display("FAIL reset_done_err: got %b%b want 00", uop_done, err); end
        nCompared++; if (dbgState !== 1'b0) begin nMismatched++; $display("FAIL reset_state: got %b want 0", dbgState); end
        issue(3'd6, 2'd1, 2'd0, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'h0000) begin nMismatched++; $display("FAIL reset_regs10: got %h want 0000", pc); end
        nCompared++; if (uop_done !== 1'b1) begin nMismatched++; $display("FAIL reset_pcload_done: got %b want 1", uop_done); end
        issue(3'd6, 2'd3, 2'd2, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'h0000) begin nMismatched++; $display("FAIL reset_regs32: got %h want 0000", pc); end
    endtask

    task automatic test_pc_wrap();
        loadReg(2'd3, 8'hFF);
        loadReg(2'd2, 8'hFF);
        issue(3'd6, 2'd3, 2'd2, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'hFFFF) begin nMismatched++; $display("FAIL pcload_ffff: got %h want ffff", pc); end
        nCompared++; if (uop_done !== 1'b1) begin nMismatched++; $display("FAIL pcload_done: got %b want 1", uop_done); end
        issue(3'd4, 2'd0, 2'd0, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'h0000) begin nMismatched++; $display("FAIL pcinc_wrap: got %h want 0000", pc); end
        nCompared++; if (uop_done !== 1'b1) begin nMismatched++; $display("FAIL pcinc_done: got %b want 1", uop_done); end
        issue(3'd5, 2'd0, 2'd0, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'hFFFF) begin nMismatched++; $display("FAIL pcdec_wrap: got %h want ffff", pc); end
        nCompared++; if (uop_done !== 1'b1) begin nMismatched++; $display("FAIL pcdec_done: got %b want 1", uop_done); end
        step();
        nCompared++; if (uop_done !== 1'b0) begin nMismatched++; $display("FAIL done_drops: got %b want 0", uop_done); end
    endtask

    task automatic test_load_wait();
        setPc(16'h1234);
        issue(3'd2, 2'd2, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nCompared++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin nMismatched++; $display("FAIL load_wait%0d_req_we: got %b%b want 10", i, mem_req, mem_we); end
            nCompared++; if (mem_addr !== 16'h1234) begin nMismatched++; $display("FAIL load_wait%0d_addr: got %h want 1234", i, mem_addr); end
            nCompared++; if (uop_ready !== 1'b0 || uop_done !== 1'b0) begin nMismatched++; $display("FAIL load_wait%0d_ready_done: got %b%b want 00", i, uop_ready, uop_done); end
            step();
        end
        mem_ack = 1'b1;
        mem_rdata = 8'h5A;
        nCompared++; if (mem_addr !== 16'h1234 || uop_ready !== 1'b0 || dbgState !== 1'b1) begin nMismatched++; $display("FAIL load_ack_cycle: got %h/%b/%b want 1234/0/1", mem_addr, uop_ready, dbgState); end
        step();
        mem_ack = 1'b0;
        nCompared++; if (uop_done !== 1'b1 || uop_ready !== 1'b1 || mem_req !== 1'b0) begin nMismatched++; $display("FAIL load_retire: got done=%b ready=%b req=%b want 1 1 0", uop_done, uop_ready, mem_req); end
        nCompared++; if (pc !== 16'h1235) begin nMismatched++; $display("FAIL load_pc_inc: got %h want 1235", pc); end
        issue(3'd6, 2'd2, 2'd2, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'h5A5A) begin nMismatched++; $display("FAIL load_data: got %h want 5a5a", pc); end
    endtask

    task automatic test_store();
        loadReg(2'd1, 8'h02);
        loadReg(2'd0, 8'h00);
        loadReg(2'd2, 8'hC3);
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        step();
        mem_ack = 1'b0;
        nCompared++; if (uop_done !== 1'b0 || mem_req !== 1'b0 || uop_ready !== 1'b1) begin nMismatched++; $display("FAIL stray_ack: got done=%b req=%b ready=%b want 0 0 1", uop_done, mem_req, uop_ready); end
        issue(3'd3, 2'd0, 2'd2, 1'b0, 1'b0);
        mem_ack = 1'b1;
        nCompared++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || uop_ready !== 1'b0) begin nMismatched++; $display("FAIL store_req: got req=%b we=%b ready=%b want 1 1 0", mem_req, mem_we, uop_ready); end
        nCompared++; if (mem_addr !== 16'h0200) begin nMismatched++; $display("FAIL store_addr: got %h want 0200", mem_addr); end
        nCompared++; if (mem_wdata !== 8'hC3) begin nMismatched++; $display("FAIL store_wdata: got %h want c3", mem_wdata); end
        step();
        mem_ack = 1'b0;
        nCompared++; if (uop_done !== 1'b1 || uop_ready !== 1'b1) begin nMismatched++; $display("FAIL store_retire: got done=%b ready=%b want 1 1", uop_done, uop_ready); end
        nCompared++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin nMismatched++; $display("FAIL store_idle_req_we: got %b%b want 00", mem_req, mem_we); end
        nCompared++; if (mem_addr !== 16'h0200 || mem_wdata !== 8'hC3) begin nMismatched++; $display("FAIL store_hold: got %h/%h want 0200/c3", mem_addr, mem_wdata); end
        nCompared++; if (pc !== 16'h5A5A) begin nMismatched++; $display("FAIL store_pc_kept: got %h want 5a5a", pc); end
    endtask

    task automatic test_back_to_back();
        loadReg(2'd0, 8'h77);
        uop_valid = 1'b1; uop_op = 3'd1; uop_rd = 2'd1; uop_rs = 2'd0;
        step();
        uop_rd = 2'd2; uop_rs = 2'd1;
        nCompared++; if (uop_ready !== 1'b1 || uop_done !== 1'b1) begin nMismatched++; $display("FAIL b2b_first: got ready=%b done=%b want 1 1", uop_ready, uop_done); end
        step();
        uop_valid = 1'b0;
        nCompared++; if (uop_done !== 1'b1) begin nMismatched++; $display("FAIL b2b_second_done: got %b want 1", uop_done); end
        issue(3'd6, 2'd2, 2'd1, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'h7777) begin nMismatched++; $display("FAIL b2b_regs: got %h want 7777", pc); end
        issue(3'd7, 2'd0, 2'd0, 1'b0, 1'b0);
        nCompared++; if (err !== 1'b1 || uop_done !== 1'b1 || pc !== 16'h7777) begin nMismatched++; $display("FAIL rsvd_op: got err=%b done=%b pc=%h want 1 1 7777", err, uop_done, pc); end
        issue(3'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        step();
        step();
        nCompared++; if (err !== 1'b1) begin nMismatched++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_mem();
        loadReg(2'd0, 8'h3C);
        issue(3'd2, 2'd0, 2'd0, 1'b1, 1'b1);
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 8'h99;
        step();
        rst = 1'b0;
        mem_ack = 1'b0;
        nCompared++; if (mem_req !== 1'b0 || uop_done !== 1'b0) begin nMismatched++; $display("FAIL rstmem_req_done: got req=%b done=%b want 0 0", mem_req, uop_done); end
        nCompared++; if (err !== 1'b0 || uop_ready !== 1'b1 || pc !== 16'hAABB) begin nMismatched++; $display("FAIL rstmem_state: got err=%b ready=%b pc=%h want 0 1 aabb", err, uop_ready, pc); end
        issue(3'd6, 2'd0, 2'd0, 1'b0, 1'b0);
        nCompared++; if (pc !== 16'h0000) begin nMismatched++; $display("FAIL rstmem_r0: got %h want 0000", pc); end
    endtask

    initial begin
        test_reset();
        test_pc_wrap();
        test_load_wait();
        test_store();
        test_back_to_back();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
